// File: rtl/dual_port_reader_pkg.sv
// Shared definitions for the dual_port RAM burst reader: FSM encoding and
// output buffer depth.
package dual_port_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/reader_skid_buf.sv
// Two-entry FIFO holding RAM words (plus last flag) in front of the output
// stream; head is always presented on rd_data.
module reader_skid_buf
  import dual_port_reader_pkg::*;
#(
  parameter int unsigned W = 9
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [BUF_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;

  // One-bit pointers toggle because the buffer is exactly two deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '{default: '0};
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd_en) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/dual_port_reader.sv
// Burst read engine for the dual_port RAM read port: streams a clamped number
// of words from a wrapping base address over a valid/ready interface.
module dual_port_reader
  import dual_port_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_LEN = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   rem_issue;
  logic [ADDR_W:0]   rem_accept;
  logic [ADDR_W:0]   len_clamped;
  logic              pending;
  logic              issue;
  logic              pop;
  logic              head_last;
  logic [1:0]        count;
  logic [2:0]        occ;

  assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
  assign pop         = m_valid & m_ready;
  // Occupancy after this cycle's pop, counting the read still in the RAM.
  assign occ         = {1'b0, count} + {2'b00, pending} - {2'b00, pop};
  assign issue       = (state == ST_RUN) && (rem_issue != '0) && (occ < 3'(BUF_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && (length != '0)) begin
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (pop && head_last) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= '0;
      rem_issue  <= '0;
      rem_accept <= '0;
      pending    <= 1'b0;
    end else begin
      pending <= issue;
      if ((state == ST_IDLE) && (state_nx == ST_RUN)) begin
        addr       <= base_addr;
        rem_issue  <= len_clamped;
        rem_accept <= len_clamped;
      end else begin
        if (issue) begin
          addr      <= addr + ADDR_W'(1);
          rem_issue <= rem_issue - ONE_LEN;
        end
        if (pending) begin
          rem_accept <= rem_accept - ONE_LEN;
        end
      end
    end
  end

  assign r_addr  = addr;
  assign m_valid = (count != 2'd0);

  reader_skid_buf #(
    .W (DATA_W + 1)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (pending),
    .wr_data ({(rem_accept == ONE_LEN), r_data}),
    .rd_en   (pop),
    .rd_data ({head_last, m_data}),
    .count   (count)
  );

  assign m_last = head_last;

endmodule

// File: tb/tb_dual_port_reader.sv
// Directed bench for dual_port_reader with a behavioural registered-read RAM.
module tb_dual_port_reader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] base_addr;
  logic [6:0] length;
  logic       busy;
  logic       done;
  logic [5:0] r_addr;
  logic [7:0] r_data;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  logic [7:0]  ram [64];
  logic [15:0] lfsr;
  int          total;
  int          bad;

  dual_port_reader #(
    .ADDR_W (6),
    .DATA_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .r_addr    (r_addr),
    .r_data    (r_data),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) r_data <= ram[r_addr];

  function automatic logic [7:0] exp_word(input logic [5:0] b, input int i);
    logic [5:0] a;
    a = b + 6'(i);
    return {2'b00, a} + 8'h10;
  endfunction

  task automatic test_reset_state();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || r_addr !== 6'd0 || m_valid !== 1'b0 ||
        m_last !== 1'b0 || m_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b r_addr=%0d m_valid=%b m_last=%b m_data=%h, want all 0",
               busy, done, r_addr, m_valid, m_last, m_data);
    end
  endtask

  // Exact cycle schedule for a 4-word burst with m_ready held high.
  task automatic test_timed(input string name, input logic [5:0] b);
    logic       ev, el, ed, eb;
    logic [5:0] ea;
    m_ready = 1'b1;
    start = 1'b1; base_addr = b; length = 7'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      ev = (k >= 3) && (k <= 6);
      el = (k == 6);
      ed = (k == 7);
      eb = (k <= 6);
      ea = b + 6'(k - 1);
      total++;
      if (m_valid !== ev || m_last !== el || done !== ed || busy !== eb) begin
        bad++;
        $display("FAIL %s_ctrl c%0d: valid=%b last=%b done=%b busy=%b, want %b %b %b %b",
                 name, k, m_valid, m_last, done, busy, ev, el, ed, eb);
      end
      if (k <= 4) begin
        total++;
        if (r_addr !== ea) begin
          bad++;
          $display("FAIL %s_addr c%0d: got %0d want %0d", name, k, r_addr, ea);
        end
      end
      if (ev) begin
        total++;
        if (m_data !== exp_word(b, k - 3)) begin
          bad++;
          $display("FAIL %s_data c%0d: got %h want %h", name, k, m_data, exp_word(b, k - 3));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Runs one burst, checking every beat, stall stability and in-flight bound.
  task automatic drive_burst(input string name, input logic [5:0] b, input logic [6:0] len,
                             input bit rnd, input int exp_n, input int abort_at,
                             input int glitch_at);
    int         beats, issued;
    logic [5:0] prev;
    logic       finished, stalled;
    logic [7:0] held;
    beats = 0; issued = 0; prev = b; finished = 1'b0; stalled = 1'b0; held = '0;
    start = 1'b1; base_addr = b; length = len;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      m_ready = rnd ? (lfsr[0] | lfsr[5]) : 1'b1;
      if (cyc == glitch_at) begin
        start = 1'b1; base_addr = b + 6'd30; length = 7'd2;
      end else begin
        start = 1'b0;
      end
      #1;
      if (r_addr !== prev) begin
        issued++;
        prev = r_addr;
      end
      total++;
      if (issued - beats > 2 || issued - beats < 0) begin
        bad++;
        $display("FAIL %s_inflight cyc%0d: issued=%0d accepted=%0d", name, cyc, issued, beats);
      end
      if (stalled) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== held) begin
          bad++;
          $display("FAIL %s_stall cyc%0d: valid=%b data=%h want 1 %h", name, cyc, m_valid, m_data, held);
        end
      end
      if (done === 1'b1) begin
        finished = 1'b1;
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL %s_busy_in_done: got %b want 0", name, busy);
        end
      end else if (m_valid === 1'b1 && m_ready === 1'b1) begin
        total++;
        if (m_data !== exp_word(b, beats) || m_last !== (beats == exp_n - 1)) begin
          bad++;
          $display("FAIL %s_beat%0d: data=%h last=%b want %h %b", name, beats, m_data, m_last,
                   exp_word(b, beats), (beats == exp_n - 1));
        end
        beats++;
        if (beats == abort_at) finished = 1'b1;
      end
      stalled = m_valid && !m_ready;
      held = m_data;
      if (!finished) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    if (abort_at < 0) begin
      total++;
      if (!finished || beats != exp_n) begin
        bad++;
        $display("FAIL %s_count: beats=%0d done_seen=%b want %0d 1", name, beats, finished, exp_n);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b1;
    start = 1'b1; base_addr = 6'd0; length = 7'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (m_valid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_pre: valid=%b busy=%b want 1 1", m_valid, busy);
    end
    #3;
    rst = 1'b1;
    #1;
    test_reset_state();
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0 || m_valid !== 1'b0 || done !== 1'b0 || r_addr !== 6'd0) begin
        bad++;
        $display("FAIL reset_idle: busy=%b valid=%b done=%b r_addr=%0d want 0 0 0 0",
                 busy, m_valid, done, r_addr);
      end
    end
  endtask

  task automatic test_length0();
    start = 1'b1; base_addr = 6'd9; length = 7'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0) begin
        bad++;
        $display("FAIL length0: busy=%b done=%b valid=%b want 0 0 0", busy, done, m_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_abort_restart();
    drive_burst("abort", 6'd10, 7'd16, 1'b0, 16, 5, -1);
    rst = 1'b1;
    #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_in_reset: done=%b busy=%b want 0 0", done, busy);
    end
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || m_valid !== 1'b0) begin
        bad++;
        $display("FAIL abort_no_done: done=%b valid=%b want 0 0", done, m_valid);
      end
    end
    drive_burst("restart", 6'd40, 7'd16, 1'b0, 16, -1, -1);
  endtask

  initial begin
    total = 0; bad = 0;
    lfsr = 16'hACE1;
    for (int i = 0; i < 64; i++) ram[i] = 8'(i) + 8'h10;
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
    #1;
    test_reset_state();
    #21;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset_state();
    test_timed("basic", 6'd0);
    test_timed("wrap", 6'd62);
    drive_burst("clamp100", 6'd20, 7'd100, 1'b0, 64, -1, -1);
    drive_burst("backpressure", 6'd5, 7'd64, 1'b1, 64, -1, -1);
    drive_burst("b2b", 6'd33, 7'd3, 1'b1, 3, -1, -1);
    test_length0();
    drive_burst("start_busy", 6'd0, 7'd8, 1'b0, 8, -1, 3);
    test_reset_mid();
    test_abort_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
